// File: rtl/mwaxis_word2byte_pkt.sv
// mwaxis_word2byte_pkt
//   Upstream feeder for one hub channel. Accepts wide sample words on an
//   AXI-Stream slave and replays them MSB byte first on an 8-bit AXI-Stream
//   master, framing packets with tlast every WORDS_PER_PKT words, on an
//   upstream tlast, or on the word that follows a flush request.
//
// Ports
//   dutclk          block clock (everything is in this domain)
//   reset           synchronous, active-high; drops any partial packet
//   s_axis_tdata    sample word in (WORD_WIDTH)
//   s_axis_tvalid   word valid
//   s_axis_tlast    close the packet after this word
//   s_axis_tready   word taken when tvalid & tready
//   m_axis_tdata    byte out (DATAWIDTH)
//   m_axis_tvalid   byte valid
//   m_axis_tlast    last byte of packet
//   m_axis_tready   downstream ready
//   flush           one-cycle pulse: close packet at next accepted word
//   pkt_done        one-cycle pulse after the tlast byte is accepted
//   pkt_count       completed packets, wraps at 16 bits
module mwaxis_word2byte_pkt #(
  parameter int WORD_WIDTH    = 32,
  parameter int DATAWIDTH     = 8,
  parameter int WORDS_PER_PKT = 256
) (
  input  logic                  dutclk,
  input  logic                  reset,
  input  logic [WORD_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic [DATAWIDTH-1:0]  m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  input  logic                  flush,
  output logic                  pkt_done,
  output logic [15:0]           pkt_count
);

  localparam int NB  = WORD_WIDTH / DATAWIDTH;
  localparam int WCW = $clog2(WORDS_PER_PKT + 1);
  localparam int BIW = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t                state_reg, state_next;
  logic [WORD_WIDTH-1:0] word_reg;
  logic [BIW-1:0]        byte_idx_reg;
  logic [WCW-1:0]        word_cnt_reg;
  logic                  last_flag_reg;
  logic                  flush_pend_reg;
  logic                  pkt_done_reg;
  logic [15:0]           pkt_count_reg;

  logic                  byte_acc;
  logic                  byte_is_last;
  logic                  word_acc;
  logic                  new_last;

  // Byte lanes of the held word, lane 0 being the most significant byte.
  logic [DATAWIDTH-1:0]  byte_lane [NB];

  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
      assign byte_lane[gi] = word_reg[WORD_WIDTH-1-gi*DATAWIDTH -: DATAWIDTH];
    end
  endgenerate

  always_ff @(posedge dutclk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next    = state_reg;
    m_axis_tvalid = (state_reg == SEND);
    byte_is_last  = (byte_idx_reg == BIW'(NB - 1));
    byte_acc      = m_axis_tvalid & m_axis_tready;
    // Ready on the final byte handshake too, so words stream with no bubble.
    s_axis_tready = (state_reg == IDLE) | (byte_acc & byte_is_last);
    word_acc      = s_axis_tvalid & s_axis_tready;
    // A flush arriving with the word applies to that word.
    new_last      = (word_cnt_reg == WCW'(WORDS_PER_PKT - 1)) | s_axis_tlast
                    | flush_pend_reg | flush;
    m_axis_tdata  = byte_lane[byte_idx_reg];
    m_axis_tlast  = last_flag_reg & byte_is_last;

    case (state_reg)
      IDLE:    if (word_acc) state_next = SEND;
      SEND:    if (byte_acc && byte_is_last && !word_acc) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge dutclk) begin
    if (reset) begin
      word_reg       <= '0;
      byte_idx_reg   <= '0;
      word_cnt_reg   <= '0;
      last_flag_reg  <= 1'b0;
      flush_pend_reg <= 1'b0;
      pkt_done_reg   <= 1'b0;
      pkt_count_reg  <= '0;
    end else begin
      if (word_acc) begin
        word_reg       <= s_axis_tdata;
        byte_idx_reg   <= '0;
        last_flag_reg  <= new_last;
        word_cnt_reg   <= new_last ? '0 : word_cnt_reg + 1'b1;
        flush_pend_reg <= 1'b0;
      end else begin
        if (byte_acc && !byte_is_last) byte_idx_reg <= byte_idx_reg + 1'b1;
        // Flushes with no word to attach to collapse into one pending flag.
        if (flush) flush_pend_reg <= 1'b1;
      end

      pkt_done_reg <= byte_acc & m_axis_tlast;
      if (byte_acc && m_axis_tlast) pkt_count_reg <= pkt_count_reg + 16'd1;
    end
  end

  assign pkt_done  = pkt_done_reg;
  assign pkt_count = pkt_count_reg;

endmodule

// File: doc/mwaxis_word2byte_pkt.md
Name: mwaxis_word2byte_pkt

Overview:
- Upstream feeder for one chN_s_axis channel of the Ethernet MAC hub.
- Accepts wide DUT sample words on an AXI-Stream slave and serialises them into 8-bit bytes, MSB first, on an AXI-Stream master.
- Inserts tlast to frame UDP-sized packets: every WORDS_PER_PKT words, on an upstream tlast, or on a flush request.
- Runs entirely in the dutclk domain; one instance per hub channel.

Parameters:
- WORD_WIDTH, 32, input word width; must be a multiple of DATAWIDTH.
- DATAWIDTH, 8, output byte width; matches the hub channel width.
- WORDS_PER_PKT, 256, maximum words per output packet (1..65535); payload must stay ≤ 1472 bytes.
- Derived, not overridable: NB = WORD_WIDTH/DATAWIDTH; WCW = $clog2(WORDS_PER_PKT+1).

Ports:
- dutclk  in  1  block clock.
- reset  in  1  synchronous, active-high reset.
- s_axis_tdata  in  WORD_WIDTH  sample word from DUT.
- s_axis_tvalid  in  1  word valid.
- s_axis_tlast  in  1  force end of packet after this word.
- s_axis_tready  out  1  word accepted when tvalid&tready.
- m_axis_tdata  out  DATAWIDTH  byte to chN_s_axis_tdata.
- m_axis_tvalid  out  1  byte valid.
- m_axis_tlast  out  1  last byte of packet.
- m_axis_tready  in  1  from chN_s_axis_tready.
- flush  in  1  one-cycle pulse: close packet at next accepted word.
- pkt_done  out  1  one-cycle pulse when the tlast byte is accepted.
- pkt_count  out  16  packets completed; wraps 65535->0.

Behaviour:
- Reset values (reset high at a dutclk edge):
  - s_axis_tready=1 (IDLE), m_axis_tvalid=0, m_axis_tlast=0, pkt_done=0, pkt_count=0.
  - word_cnt=0, byte_idx=0, flush_pend=0. Any held word is discarded.
- States:
  - IDLE: no word held.
  - SEND: word register holds a word; byte_idx 0..NB-1.
- Output signals:
  - s_axis_tready = (state==IDLE) | (m_axis_tvalid & m_axis_tready & byte_idx==NB-1). This gives back-to-back words with no bubble.
  - m_axis_tvalid = (state==SEND).
  - m_axis_tdata = word_reg[WORD_WIDTH-1-byte_idx*DATAWIDTH -: DATAWIDTH], i.e. MSB byte first. It is a registered-source mux and stays stable while tvalid & !tready.
  - m_axis_tlast = last_flag & (byte_idx==NB-1).
- On word accept (s_axis_tvalid & s_axis_tready):
  - Load word_reg, set byte_idx=0, go to SEND.
  - last_flag = (word_cnt==WORDS_PER_PKT-1) | s_axis_tlast | flush_pend | flush.
  - word_cnt = last_flag ? 0 : word_cnt+1.
  - Clear flush_pend.
- On byte accept (m_axis_tvalid & m_axis_tready):
  - If byte_idx < NB-1: byte_idx+1.
  - Else: go to IDLE, unless a new word is accepted in the same cycle, in which case reload and stay in SEND.
- Latency: word accepted at edge T gives its first byte valid from T+1. Throughput is NB cycles per word with m_axis_tready held high.
- flush:
  - Pulse sets flush_pend. A flush coinciding with a word accept applies to that word.
  - Flush while IDLE with no incoming word: pending until the next word.
  - Multiple flushes before a word collapse to one.
  - A flush never creates an empty packet.
- pkt_done and pkt_count: pkt_done asserts the cycle after the tlast byte is accepted, for 1 cycle; pkt_count increments at the same time.
- Backpressure: m_axis_tready=0 holds tdata/tvalid/tlast unchanged indefinitely, and s_axis_tready stays 0 while in SEND.
- WORDS_PER_PKT=1: every byte group ends with tlast.
- Reset mid-packet: the partial packet is dropped with no tlast emitted. The downstream hub sees a truncated stream; this is accepted by design.

Test Plan:
- WORD_WIDTH=32, WORDS_PER_PKT=4, m_axis_tready=1; send words 0x01020304..0x0D0E0F10 back-to-back -> bytes 01,02,…,10 on 16 consecutive cycles; tlast only on byte 0x10; pkt_done once; pkt_count=1; s_axis_tready high every 4th cycle.
- Same config, 9 words -> tlast on bytes 16 and 32; word 9 held with no tlast; pkt_count=2.
- Word 2 sent with s_axis_tlast=1 -> tlast on byte 8; word_cnt restarts, so the next packet closes after 4 more words.
- flush pulse in IDLE, then word 0xAABBCCDD -> AA,BB,CC,DD with tlast on DD; a second flush with no word produces no output.
- m_axis_tready toggling 1,0,0,1… during a packet -> no byte lost or duplicated; tdata stable while stalled; total 16 bytes.
- reset asserted after 6 bytes of a packet -> next cycle tvalid=0, pkt_count=0; new 4-word packet emits a correct 16-byte frame with tlast on byte 16.
